// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter for the shared data-memory port, grant held per single/burst transaction.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed M1-over-M0 priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LENGTH = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_wrb,
  input  logic                  m1_wrb,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [1:0]            m0_burst,
  input  logic [1:0]            m1_burst,
  input  logic [3:0]            m0_bstrobe,
  input  logic [3:0]            m1_bstrobe,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_ack,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_req,
  output logic                  mem_wrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_burst,
  output logic [3:0]            mem_bstrobe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  mem_stall
);
  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BURST_LENGTH);
  state_t state_q, state_d;
  logic owner_q, owner_d, burst_q, burst_d, win, act, o_req;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] o_burst;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  always_comb begin
    win = (m0_req & m1_req) ? ~last_q : m1_req;
    last_d = (state_q == IDLE && (m0_req | m1_req) && !mem_stall) ? win : last_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= 1'b0;
    else last_q <= last_d;
`else
  assign win = m1_req;
`endif
  // Grants derive only from registered state/owner; nothing is driven outside ACTIVE.
  always_comb begin
    act = state_q == ACTIVE;
    o_req = owner_q ? m1_req : m0_req;
    o_burst = owner_q ? m1_burst : m0_burst;
    m0_gnt = act & ~owner_q;
    m1_gnt = act & owner_q;
    m0_ack = mem_ack & m0_gnt;
    m1_ack = mem_ack & m1_gnt;
    m0_rdata = m0_gnt ? mem_rdata : '0;
    m1_rdata = m1_gnt ? mem_rdata : '0;
    mem_req = act & o_req;
    mem_wrb = act & (owner_q ? m1_wrb : m0_wrb);
    mem_addr = act ? (owner_q ? m1_addr : m0_addr) : '0;
    mem_wdata = act ? (owner_q ? m1_wdata : m0_wdata) : '0;
    mem_bstrobe = act ? (owner_q ? m1_bstrobe : m0_bstrobe) : '0;
    mem_burst = {1'b0, act && o_burst == 2'b01};
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if ((m0_req | m1_req) && !mem_stall) begin
        state_d = ACTIVE;
        owner_d = win;
        burst_d = (win ? m1_burst : m0_burst) == 2'b01;
      end
      ACTIVE: if (!mem_stall) begin
        if (!o_req) state_d = RELEASE;
        else if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (!burst_q || cnt_d == LAST) state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        owner_d = 1'b0;
        burst_d = 1'b0;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      burst_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; expected beats queued when ACKs are driven, checked at the owner's ack.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 0;
  logic m0_req = 0, m1_req = 0, m0_wrb = 0, m1_wrb = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [1:0] m0_burst = 0, m1_burst = 0;
  logic [3:0] m0_bstrobe = 0, m1_bstrobe = 0;
  logic m0_gnt, m1_gnt, m0_ack, m1_ack, mem_req, mem_wrb;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [1:0] mem_burst;
  logic [3:0] mem_bstrobe;
  logic [31:0] mem_rdata = 0;
  logic mem_ack = 0, mem_stall = 0;
  typedef struct { logic id; logic [31:0] d; logic [31:0] a; } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, last_k = 0;
  logic last_id = 0, p;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wrb(m0_wrb), .m1_wrb(m1_wrb),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_burst(m0_burst), .m1_burst(m1_burst), .m0_bstrobe(m0_bstrobe), .m1_bstrobe(m1_bstrobe),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_wrb(mem_wrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_burst(mem_burst), .mem_bstrobe(mem_bstrobe),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic pick();
`ifdef ARB_ROUND_ROBIN_EN
    return (m0_req & m1_req) ? ~last_id : m1_req;
`else
    return m1_req;
`endif
  endfunction
  task automatic wait_gnt(input logic id);
    int k = 0;
    while (!(m0_gnt | m1_gnt) && k < 8) begin
      tick;
      k++;
    end
    last_k = k;
    chk("gnt_seen", m0_gnt | m1_gnt, 1);
    chk("gnt_id", {m1_gnt, m0_gnt}, id ? 2'b10 : 2'b01);
    chk("gnt_mem_req", mem_req, 1);
    last_id = id;
  endtask
  task automatic beat(input logic id, input logic [31:0] d);
    chk("gnt_hold", id ? m1_gnt : m0_gnt, 1);
    mem_ack = 1;
    mem_rdata = d;
    sb.push_back(exp_t'{id, d, id ? m1_addr : m0_addr});
    tick;
    mem_ack = 0;
  endtask
  task automatic done(input logic id);
    chk("rel_gnt", m0_gnt | m1_gnt, 0);
    chk("rel_req", mem_req, 0);
    if (id) m1_req = 0;
    else m0_req = 0;
    tick;
  endtask
  always @(negedge clk)
    if (rst && !mem_stall && (m0_ack | m1_ack)) begin
      if (sb.size() == 0) chk("spurious_ack", {m1_ack, m0_ack}, 0);
      else begin
        e = sb.pop_front();
        chk("ack_id", {m1_ack, m0_ack}, e.id ? 2'b10 : 2'b01);
        chk("rdata", e.id ? m1_rdata : m0_rdata, e.d);
        chk("other_rdata", e.id ? m0_rdata : m1_rdata, 0);
        chk("addr", mem_addr, e.a);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    m0_req = 1;
    m1_req = 1;
    m0_addr = 32'h44;
    mem_ack = 1;
    mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {m0_gnt, m1_gnt, m0_ack, m1_ack, mem_req, mem_wrb, mem_burst, mem_bstrobe}, 0);
    chk("rst_bus", mem_addr | mem_wdata | m0_rdata | m1_rdata, 0);
    mem_ack = 0;
    mem_rdata = 0;
    rst = 1;
    chk("rst_rel_req", mem_req, 0);
    tick;
    chk("first_gnt", {m1_gnt, m0_gnt}, 2'b10);
    last_id = 1;
    m0_req = 0;
    m1_req = 0;
    tick;
    chk("drop_rel", m0_gnt | m1_gnt | mem_req, 0);
    tick;
    m0_addr = 32'h0000_0010;
    m0_req = 1;
    wait_gnt(0);
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_wrb", mem_wrb, 0);
    tick;
    beat(0, 32'hDEAD_BEEF);
    done(0);
    m1_addr = 32'h20;
    m1_wdata = 32'hCAFE_F00D;
    m1_bstrobe = 4'b0101;
    m1_wrb = 1;
    m1_burst = 2'b11;
    m1_req = 1;
    wait_gnt(1);
    chk("wr_fwd", {mem_wrb, mem_burst, mem_bstrobe}, {1'b1, 2'b00, 4'b0101});
    chk("wr_wdata", mem_wdata, 32'hCAFE_F00D);
    beat(1, 32'h1);
    done(1);
    m1_wrb = 0;
    m1_burst = 2'b01;
    m1_addr = 32'h100;
    m0_addr = 32'h200;
    m1_req = 1;
    wait_gnt(1);
    m0_req = 1;
    chk("burst_code", mem_burst, 2'b01);
    for (int k = 0; k < 8; k++) begin
      chk("m0_gnt_in_burst", m0_gnt, 0);
      beat(1, 32'hB000 + 32'(k));
    end
    done(1);
    wait_gnt(0);
    beat(0, 32'h0A0A_0A0A);
    done(0);
    m1_req = 1;
    wait_gnt(1);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        mem_stall = 1;
        mem_ack = 1;
        repeat (3) tick;
        chk("stall_hold", m1_gnt, 1);
        mem_stall = 0;
        mem_ack = 0;
      end
      beat(1, 32'h5000 + 32'(k));
    end
    done(1);
    m1_req = 1;
    wait_gnt(1);
    m0_req = 1;
    for (int k = 0; k < 3; k++) beat(1, 32'hAB00 + 32'(k));
    m1_req = 0;
    tick;
    chk("abort_rel", m0_gnt | m1_gnt | mem_req, 0);
    tick;
    wait_gnt(0);
    beat(0, 32'h0000_A0A0);
    done(0);
    m1_req = 1;
    wait_gnt(1);
    for (int k = 0; k < 5; k++) beat(1, 32'hC000 + 32'(k));
    rst = 0;
    #1;
    chk("midrst_out", {m1_gnt, mem_req, m1_ack}, 0);
    tick;
    rst = 1;
    last_id = 0;
    chk("postrst_req", mem_req, 0);
    wait_gnt(1);
    for (int k = 0; k < 8; k++) beat(1, 32'hD000 + 32'(k));
    done(1);
    m0_burst = 2'b00;
    m1_burst = 2'b00;
    m0_req = 1;
    m1_req = 1;
    for (int i = 0; i < 4; i++) begin
      p = pick();
      wait_gnt(p);
      chk("b2b_latency", last_k, 1);
      beat(p, 32'hE000 + 32'(i));
      chk("cont_rel", m0_gnt | m1_gnt | mem_req, 0);
      tick;
    end
    m1_req = 0;
    wait_gnt(0);
    beat(0, 32'hF00F);
    done(0);
    tick;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master arbiter in front of the shared DATA_MEMORY slave port. M0 is the instruction-fetch / I-cache refill path; M1 is the LSU / D-cache path.
- Grants the single memory port to one master at a time and holds the grant for a whole transaction: one beat for single accesses, BURST_LENGTH beats for bursts.
- Steers that master's request onto the memory port and returns ACK/RDATA only to the owner.

Parameters:
- ADDR_WIDTH, 32, address width on master and memory ports
- DATA_WIDTH, 32, data width
- BURST_LENGTH, 8, beats per burst transaction (BURST==2'b01)
- CNT_WIDTH, 4, width of the beat counter; must hold BURST_LENGTH

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  master request; held until transaction completes
- m0_wrb, m1_wrb  in  1  1=write, 0=read
- m0_addr, m1_addr  in  ADDR_WIDTH  byte address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_burst, m1_burst  in  2  2'b00 single, 2'b01 burst; other codes treated as single
- m0_bstrobe, m1_bstrobe  in  4  byte enables
- m0_gnt, m1_gnt  out  1  registered grant; one-hot or zero
- m0_ack, m1_ack  out  1  memory ACK gated to owner
- m0_rdata, m1_rdata  out  DATA_WIDTH  memory RDATA gated to owner; 0 otherwise
- mem_req  out  1  to memory REQ
- mem_wrb  out  1  to memory WRB
- mem_addr  out  ADDR_WIDTH  to memory ADDR
- mem_wdata  out  DATA_WIDTH  to memory WDATA
- mem_burst  out  2  to memory BURST
- mem_bstrobe  out  4  to memory BSTROBE
- mem_rdata  in  DATA_WIDTH  from memory RDATA
- mem_ack  in  1  from memory ACK
- mem_stall  in  1  from memory STALL

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=none, beat_cnt=0
  - all gnt/ack outputs 0; all rdata outputs 0
  - mem_req=0, mem_wrb=0, mem_addr=0, mem_wdata=0, mem_burst=0, mem_bstrobe=0
  - Reset mid-transaction aborts it immediately; no memory access is issued after rst deasserts until a fresh arbitration.
- FSM states: IDLE, ACTIVE, RELEASE.
- IDLE:
  - If any mX_req=1 and mem_stall=0: pick a winner, register owner, assert its gnt, latch the transaction type (burst if BURST==2'b01), go to ACTIVE.
  - Priority: fixed, M1 (data) over M0.
  - Latency: mX_req high at edge N gives gnt and mem_req high after edge N+1.
- ACTIVE:
  - mem_* outputs mux the owner's inputs combinationally; mem_req = owner req.
  - Non-owner inputs are ignored.
  - beat_cnt increments on a cycle with mem_ack=1 and mem_stall=0; mem_stall=1 freezes the counter and the FSM.
  - Single: the first counted ACK completes the transaction.
  - Burst: the counted ACK that brings beat_cnt to BURST_LENGTH completes it.
  - On completion go to RELEASE.
  - If the owner drops req before completion, the transaction is aborted and the FSM goes to RELEASE; the abort is not an error.
- RELEASE (exactly 1 cycle):
  - gnt=0, mem_req=0, beat_cnt cleared, owner cleared, go to IDLE.
  - Guarantees mem_req low for at least one cycle between transactions, so the memory's ACK/counter logic re-arms.
- mX_ack = mem_ack & mX_gnt. mX_rdata = mX_gnt ? mem_rdata : 0.
- Back-to-back: one master requesting continuously gets one transaction every (beats + 2) cycles minimum.
- Simultaneous requests in IDLE resolve within the same cycle; the loser holds req and wins the next arbitration if the winner has released.
- BURST codes 2'b10/2'b11 are forwarded as 2'b00 and handled as single.
- The owner's burst field is sampled at grant; changes mid-transaction are ignored for completion counting.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_owner register (reset to M0) selects the non-last master on contention, i.e. alternating grants under continuous dual requests.
- Undefined: fixed priority, M1 over M0; last_owner logic absent.

Test Plan:
- Reset: rst=0 with m0_req=m1_req=1 -> all outputs 0; after rst=1, first grant appears 1 cycle later.
- Single read: m0_req=1, burst=00, addr=0x0000_0010; mem_ack on 2nd ACTIVE cycle with mem_rdata=0xDEADBEEF -> m0_ack=1, m0_rdata=0xDEADBEEF for 1 cycle, then RELEASE, then m0_gnt=0.
- Burst: m1_req=1, burst=01; 8 mem_ack pulses -> m1_ack pulses 8 times, beat_cnt reaches 8, RELEASE, m0 never granted during the burst.
- Contention: m0_req and m1_req both 1 in IDLE -> fixed priority gives M1 first, M0 next; with ARB_ROUND_ROBIN_EN, grants alternate M1, M0, M1, M0 over 4 singles.
- Stall: mem_stall=1 for 3 cycles mid-burst with mem_ack=1 -> beat_cnt holds; burst completes only after 8 unstalled ACKs.
- Abort and reset mid-burst: owner drops req after 3 beats -> RELEASE then IDLE, other master granted next. Separately, rst=0 after 5 beats -> immediate IDLE with mem_req=0.
